// File: rtl/uart_cfg.sv
// uart_cfg: single-clock UART transceiver with a configurable frame format.
// Tx runs from a private bit-period counter that restarts on every accepted
// request. Rx uses a free-running oversample tick with mid-bit sampling, and
// reports parity, frame and overrun errors behind a valid/read handshake.
module uart_cfg #(
  parameter int clk_freq   = 100_000_000,
  parameter int baud_rate  = 9_600,
  parameter int oversample = 16,
  parameter int data_bits  = 8,
  parameter int parity     = 0,
  parameter int stop_bits  = 1
) (
  input  logic                 tck,
  input  logic                 reset,
  input  logic                 TxEnable,
  input  logic [data_bits-1:0] TxData,
  output logic                 TxD,
  output logic                 TxBusy,
  output logic                 TxDone,
  input  logic                 RxD,
  output logic [data_bits-1:0] RxData,
  output logic                 RxValid,
  input  logic                 RxRead,
  output logic                 RxParityErr,
  output logic                 RxFrameErr,
  output logic                 RxOverrun
);

  localparam int DIV        = clk_freq / (baud_rate * oversample);
  localparam int BIT_CYCLES = oversample * DIV;
  localparam int BCW        = $clog2(BIT_CYCLES);
  localparam int DCW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OCW        = $clog2(oversample);

  localparam logic [BCW-1:0] BIT_LAST   = BCW'(BIT_CYCLES - 1);
  localparam logic [DCW-1:0] DIV_LAST   = DCW'(DIV - 1);
  localparam logic [OCW-1:0] OS_LAST    = OCW'(oversample - 1);
  localparam logic [OCW-1:0] HALF_LAST  = OCW'(oversample / 2 - 1);
  localparam logic [3:0]     DATA_LAST  = 4'(data_bits - 1);
  localparam logic           STOP_LAST  = (stop_bits == 2);
  localparam logic           HAS_PARITY = (parity != 0);
  localparam logic           ODD        = (parity == 1);

  // Reject parameter sets the datapath cannot represent.
  if (DIV < 1) begin : g_div_check
    $error("uart_cfg: clk_freq is too low for baud_rate*oversample");
  end
  if (data_bits < 5 || data_bits > 9) begin : g_bits_check
    $error("uart_cfg: data_bits must be 5..9");
  end
  if (oversample < 4 || (oversample % 2) != 0) begin : g_os_check
    $error("uart_cfg: oversample must be even and at least 4");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------- Tx
  state_t               tx_state, tx_state_next;
  logic [BCW-1:0]       tx_cyc, tx_cyc_next;
  logic [3:0]           tx_bit, tx_bit_next;
  logic                 tx_stop, tx_stop_next;
  logic [data_bits-1:0] tx_sh, tx_sh_next;
  logic                 tx_par, tx_par_next;
  logic                 txd_next, busy_next, done_next;

  // Tx next state: each bit holds for BIT_CYCLES; TxD is registered, so the
  // next line level is derived from the state being entered.
  always_comb begin
    tx_state_next = tx_state;
    tx_cyc_next   = tx_cyc + BCW'(1);
    tx_bit_next   = tx_bit;
    tx_stop_next  = tx_stop;
    tx_sh_next    = tx_sh;
    tx_par_next   = tx_par;
    txd_next      = TxD;
    busy_next     = TxBusy;
    if (tx_state == S_IDLE) begin
      tx_cyc_next = '0;
      if (TxEnable) begin
        tx_sh_next    = TxData;
        tx_par_next   = ODD ? ~^TxData : ^TxData;
        tx_state_next = S_START;
        txd_next      = 1'b0;
        busy_next     = 1'b1;
      end
    end else if (tx_cyc == BIT_LAST) begin
      tx_cyc_next = '0;
      case (tx_state)
        S_START: begin
          tx_state_next = S_DATA;
          tx_bit_next   = '0;
          txd_next      = tx_sh[0];
        end
        S_DATA: begin
          if (tx_bit == DATA_LAST) begin
            if (HAS_PARITY) begin
              tx_state_next = S_PARITY;
              txd_next      = tx_par;
            end else begin
              tx_state_next = S_STOP;
              tx_stop_next  = 1'b0;
              txd_next      = 1'b1;
            end
          end else begin
            tx_bit_next = tx_bit + 4'(1);
            tx_sh_next  = tx_sh >> 1;
            txd_next    = tx_sh[1];
          end
        end
        S_PARITY: begin
          tx_state_next = S_STOP;
          tx_stop_next  = 1'b0;
          txd_next      = 1'b1;
        end
        S_STOP: begin
          if (tx_stop == STOP_LAST) begin
            tx_state_next = S_IDLE;
            busy_next     = 1'b0;
            txd_next      = 1'b1;
          end else begin
            tx_stop_next = 1'b1;
          end
        end
        default: begin
          tx_state_next = S_IDLE;
          busy_next     = 1'b0;
          txd_next      = 1'b1;
        end
      endcase
    end
    // Done is high exactly while the final stop bit is in its last cycle.
    done_next = (tx_state_next == S_STOP) && (tx_stop_next == STOP_LAST) &&
                (tx_cyc_next == BIT_LAST);
  end

  // Tx state register; reset forces the line high and aborts any frame.
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cyc   <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      TxD      <= 1'b1;
      TxBusy   <= 1'b0;
      TxDone   <= 1'b0;
    end else begin
      tx_state <= tx_state_next;
      tx_cyc   <= tx_cyc_next;
      tx_bit   <= tx_bit_next;
      tx_stop  <= tx_stop_next;
      tx_sh    <= tx_sh_next;
      tx_par   <= tx_par_next;
      TxD      <= txd_next;
      TxBusy   <= busy_next;
      TxDone   <= done_next;
    end
  end

  // ---------------------------------------------------------------- Rx
  logic           rx_s1, rx_s2, rx_prev;
  logic [DCW-1:0] tk_cnt;
  logic           tick;

  assign tick = (tk_cnt == DIV_LAST);

  // RxD synchroniser, edge history and free-running oversample tick.
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      tk_cnt  <= '0;
    end else begin
      rx_s1   <= RxD;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      tk_cnt  <= tick ? '0 : tk_cnt + DCW'(1);
    end
  end

  state_t               rx_state, rx_state_next;
  logic [OCW-1:0]       rx_os, rx_os_next;
  logic [3:0]           rx_bit, rx_bit_next;
  logic [data_bits-1:0] rx_sh, rx_sh_next;
  logic                 rx_par, rx_par_next;
  logic                 rx_done;
  logic [data_bits-1:0] rxdata_next;
  logic                 valid_next, perr_next, ferr_next, ovr_next;

  // Rx next state: half a bit into the start bit, then one full bit per
  // sample; the stop sample completes the frame and updates the handshake.
  always_comb begin
    rx_state_next = rx_state;
    rx_os_next    = rx_os;
    rx_bit_next   = rx_bit;
    rx_sh_next    = rx_sh;
    rx_par_next   = rx_par;
    rx_done       = 1'b0;
    rxdata_next   = RxData;
    valid_next    = RxValid;
    perr_next     = RxParityErr;
    ferr_next     = RxFrameErr;
    ovr_next      = RxOverrun;
    case (rx_state)
      S_IDLE: begin
        rx_os_next = '0;
        if (rx_prev && !rx_s2) rx_state_next = S_START;
      end
      S_START: begin
        if (tick) begin
          if (rx_os == HALF_LAST) begin
            rx_os_next    = '0;
            rx_bit_next   = '0;
            rx_state_next = rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_os_next = rx_os + OCW'(1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (rx_os == OS_LAST) begin
            rx_os_next = '0;
            rx_sh_next = {rx_s2, rx_sh[data_bits-1:1]};
            if (rx_bit == DATA_LAST) begin
              rx_state_next = HAS_PARITY ? S_PARITY : S_STOP;
            end else begin
              rx_bit_next = rx_bit + 4'(1);
            end
          end else begin
            rx_os_next = rx_os + OCW'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          if (rx_os == OS_LAST) begin
            rx_os_next    = '0;
            rx_par_next   = rx_s2;
            rx_state_next = S_STOP;
          end else begin
            rx_os_next = rx_os + OCW'(1);
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_os == OS_LAST) begin
            rx_os_next    = '0;
            rx_done       = 1'b1;
            rx_state_next = S_IDLE;
          end else begin
            rx_os_next = rx_os + OCW'(1);
          end
        end
      end
      default: rx_state_next = S_IDLE;
    endcase

    if (rx_done) begin
      rxdata_next = rx_sh;
      perr_next   = HAS_PARITY && (rx_par != (ODD ? ~^rx_sh : ^rx_sh));
      ferr_next   = !rx_s2;
      valid_next  = 1'b1;
      ovr_next    = RxRead ? 1'b0 : (RxOverrun | RxValid);
    end else if (RxRead && RxValid) begin
      valid_next = 1'b0;
      ovr_next   = 1'b0;
    end
  end

  // Rx state and host-visible receive registers.
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      rx_state    <= S_IDLE;
      rx_os       <= '0;
      rx_bit      <= '0;
      rx_sh       <= '0;
      rx_par      <= 1'b0;
      RxData      <= '0;
      RxValid     <= 1'b0;
      RxParityErr <= 1'b0;
      RxFrameErr  <= 1'b0;
      RxOverrun   <= 1'b0;
    end else begin
      rx_state    <= rx_state_next;
      rx_os       <= rx_os_next;
      rx_bit      <= rx_bit_next;
      rx_sh       <= rx_sh_next;
      rx_par      <= rx_par_next;
      RxData      <= rxdata_next;
      RxValid     <= valid_next;
      RxParityErr <= perr_next;
      RxFrameErr  <= ferr_next;
      RxOverrun   <= ovr_next;
    end
  end

endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg: directed bench for uart_cfg. Instance a is 8N1, instance b is
// 7 data bits / even parity / 2 stop bits; both at DIV=1 (16 cycles per bit).
// Each Rx input is either looped from its own TxD or driven by the bench.
module tb_uart_cfg;

  logic tck = 1'b0;
  always #5 tck = ~tck;

  logic       reset;
  logic       txen_a, txen_b, read_a, read_b;
  logic [7:0] txdata_a, rxdata_a;
  logic [6:0] txdata_b, rxdata_b;
  logic       txd_a, busy_a, done_a, valid_a, perr_a, ferr_a, ovr_a;
  logic       txd_b, busy_b, done_b, valid_b, perr_b, ferr_b, ovr_b;
  logic       loop_a, loop_b, drv_a, drv_b;
  logic       rxd_a, rxd_b;
  logic       sel;

  assign rxd_a = loop_a ? txd_a : drv_a;
  assign rxd_b = loop_b ? txd_b : drv_b;

  uart_cfg #(.clk_freq(16_000_000), .baud_rate(1_000_000), .oversample(16),
             .data_bits(8), .parity(0), .stop_bits(1)) dut_a (
    .tck(tck), .reset(reset), .TxEnable(txen_a), .TxData(txdata_a),
    .TxD(txd_a), .TxBusy(busy_a), .TxDone(done_a), .RxD(rxd_a),
    .RxData(rxdata_a), .RxValid(valid_a), .RxRead(read_a),
    .RxParityErr(perr_a), .RxFrameErr(ferr_a), .RxOverrun(ovr_a));

  uart_cfg #(.clk_freq(16_000_000), .baud_rate(1_000_000), .oversample(16),
             .data_bits(7), .parity(2), .stop_bits(2)) dut_b (
    .tck(tck), .reset(reset), .TxEnable(txen_b), .TxData(txdata_b),
    .TxD(txd_b), .TxBusy(busy_b), .TxDone(done_b), .RxD(rxd_b),
    .RxData(rxdata_b), .RxValid(valid_b), .RxRead(read_b),
    .RxParityErr(perr_b), .RxFrameErr(ferr_b), .RxOverrun(ovr_b));

  // Observation of the currently selected instance
  logic       o_txd, o_busy, o_done, o_valid, o_perr, o_ferr, o_ovr;
  logic [8:0] o_rxdata;
  assign o_txd    = sel ? txd_b   : txd_a;
  assign o_busy   = sel ? busy_b  : busy_a;
  assign o_done   = sel ? done_b  : done_a;
  assign o_valid  = sel ? valid_b : valid_a;
  assign o_perr   = sel ? perr_b  : perr_a;
  assign o_ferr   = sel ? ferr_b  : ferr_a;
  assign o_ovr    = sel ? ovr_b   : ovr_a;
  assign o_rxdata = sel ? {2'b00, rxdata_b} : {1'b0, rxdata_a};

  int errors = 0;
  int checks = 0;

  task automatic set_en(input logic v);
    if (sel) txen_b = v; else txen_a = v;
  endtask

  task automatic set_read(input logic v);
    if (sel) read_b = v; else read_a = v;
  endtask

  task automatic set_drv(input logic v);
    if (sel) drv_b = v; else drv_a = v;
  endtask

  task automatic set_loop(input logic v);
    if (sel) loop_b = v; else loop_a = v;
  endtask

  task automatic pulse_read();
    @(negedge tck); set_read(1'b1);
    @(negedge tck); set_read(1'b0);
  endtask

  // Sends one frame and records what the line and status outputs did.
  // Index i counts negedges from the first cycle of the start bit.
  task automatic send_frame(input logic [8:0] data, input int nbits,
                            input int extra_en_at, input int read_at,
                            output logic [11:0] seen, output int done_at,
                            output int done_cnt, output int busy_low,
                            output logic busy_end, output int rx_at);
    seen = '0; done_at = -1; done_cnt = 0; busy_low = 0; busy_end = 1'b1; rx_at = -1;
    @(negedge tck);
    if (sel) txdata_b = data[6:0]; else txdata_a = data[7:0];
    set_en(1'b1);
    for (int i = 0; i <= nbits * 16; i++) begin
      @(negedge tck);
      set_en(i == extra_en_at);
      set_read(i == read_at);
      if (i < nbits * 16) begin
        if (i % 16 == 8) seen[i/16] = o_txd;
        if (!o_busy) busy_low++;
      end else begin
        busy_end = o_busy;
      end
      if (o_done) begin
        if (done_cnt == 0) done_at = i;
        done_cnt++;
      end
      if (o_valid && rx_at < 0) rx_at = i;
    end
    set_en(1'b0);
    set_read(1'b0);
    $display("txn: tx data=0x%0h inst=%0d done_at=%0d done_cnt=%0d rx_at=%0d",
             data, sel, done_at, done_cnt, rx_at);
  endtask

  // Drives a hand-built bit sequence onto the selected RxD, 16 cycles per bit.
  task automatic drive_rx(input logic [11:0] bits, input int nbits, output int rx_at);
    rx_at = -1;
    set_drv(1'b1);
    set_loop(1'b0);
    for (int i = 0; i < nbits * 16 + 16; i++) begin
      @(negedge tck);
      set_drv((i < nbits * 16) ? bits[i/16] : 1'b1);
      if (o_valid && rx_at < 0) rx_at = i;
    end
    $display("txn: rx drive bits=0x%0h inst=%0d rx_at=%0d data=0x%0h", bits, sel, rx_at, o_rxdata);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge tck);
    checks++;
    if ({txd_a, busy_a, done_a, valid_a, perr_a, ferr_a, ovr_a} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_a: got txd,busy,done,valid,perr,ferr,ovr=%b expected 1000000",
               {txd_a, busy_a, done_a, valid_a, perr_a, ferr_a, ovr_a});
    end
    checks++;
    if ({txd_b, busy_b, done_b, valid_b, perr_b, ferr_b, ovr_b} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_b: got txd,busy,done,valid,perr,ferr,ovr=%b expected 1000000",
               {txd_b, busy_b, done_b, valid_b, perr_b, ferr_b, ovr_b});
    end
    checks++;
    if ({rxdata_a, 1'b0, rxdata_b} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rxdata: got a=0x%0h b=0x%0h expected 0", rxdata_a, rxdata_b);
    end
    reset = 1'b1;
    repeat (2) @(negedge tck);
    $display("txn: reset released");
  endtask

  task automatic test_loopback_8n1();
    logic [11:0] seen; int done_at, done_cnt, busy_low, rx_at; logic busy_end;
    sel = 1'b0; loop_a = 1'b1;
    send_frame(9'h0A5, 10, -1, -1, seen, done_at, done_cnt, busy_low, busy_end, rx_at);
    checks++;
    if (seen !== 12'h34A) begin errors++; $display("FAIL 8n1_bits: got 0x%0h expected 0x34a", seen); end
    checks++;
    if (done_at !== 159 || done_cnt !== 1) begin
      errors++; $display("FAIL 8n1_done: got at=%0d count=%0d expected at=159 count=1", done_at, done_cnt);
    end
    checks++;
    if (busy_low !== 0 || busy_end !== 1'b0) begin
      errors++; $display("FAIL 8n1_busy: got low_cycles=%0d end=%b expected 0 and 0", busy_low, busy_end);
    end
    checks++;
    if (rx_at < 154 || rx_at > 156) begin
      errors++; $display("FAIL 8n1_rx_latency: got %0d expected 154..156", rx_at);
    end
    checks++;
    if ({o_valid, o_perr, o_ferr, o_ovr} !== 4'b1000 || o_rxdata !== 9'h0A5) begin
      errors++; $display("FAIL 8n1_rx: got data=0x%0h vpfo=%b expected 0xa5 1000",
                         o_rxdata, {o_valid, o_perr, o_ferr, o_ovr});
    end
    pulse_read();
    checks++;
    if (o_valid !== 1'b0 || o_rxdata !== 9'h0A5) begin
      errors++; $display("FAIL 8n1_read: got valid=%b data=0x%0h expected 0 0xa5", o_valid, o_rxdata);
    end
  endtask

  task automatic test_parity_7e2();
    logic [11:0] seen; int done_at, done_cnt, busy_low, rx_at; logic busy_end;
    sel = 1'b1; loop_b = 1'b1;
    send_frame(9'h007, 11, -1, -1, seen, done_at, done_cnt, busy_low, busy_end, rx_at);
    checks++;
    if (seen !== 12'h70E) begin errors++; $display("FAIL 7e2_bits: got 0x%0h expected 0x70e", seen); end
    checks++;
    if (done_at !== 175 || busy_end !== 1'b0) begin
      errors++; $display("FAIL 7e2_length: got done_at=%0d busy_end=%b expected 175 0", done_at, busy_end);
    end
    checks++;
    if (o_valid !== 1'b1 || o_rxdata !== 9'h007 || o_perr !== 1'b0) begin
      errors++; $display("FAIL 7e2_rx: got valid=%b data=0x%0h perr=%b expected 1 0x7 0",
                         o_valid, o_rxdata, o_perr);
    end
    pulse_read();
    drive_rx(12'h60E, 11, rx_at);
    checks++;
    if (rx_at < 0 || o_perr !== 1'b1 || o_ferr !== 1'b0 || o_rxdata !== 9'h007) begin
      errors++; $display("FAIL 7e2_parity_err: got rx_at=%0d perr=%b ferr=%b data=0x%0h expected perr=1 ferr=0 0x7",
                         rx_at, o_perr, o_ferr, o_rxdata);
    end
    pulse_read();
    checks++;
    if (o_valid !== 1'b0 || o_perr !== 1'b1) begin
      errors++; $display("FAIL 7e2_flag_hold: got valid=%b perr=%b expected 0 1", o_valid, o_perr);
    end
    loop_b = 1'b1;
  endtask

  task automatic test_frame_err();
    int rx_at;
    sel = 1'b0;
    drive_rx(12'h078, 10, rx_at);
    checks++;
    if (rx_at < 0 || o_ferr !== 1'b1 || o_perr !== 1'b0 || o_rxdata !== 9'h03C) begin
      errors++; $display("FAIL frame_err: got rx_at=%0d ferr=%b perr=%b data=0x%0h expected ferr=1 perr=0 0x3c",
                         rx_at, o_ferr, o_perr, o_rxdata);
    end
    pulse_read();
    loop_a = 1'b1;
  endtask

  task automatic test_overrun();
    logic [11:0] seen; int done_at, done_cnt, busy_low, rx_at, lat; logic busy_end;
    sel = 1'b0; loop_a = 1'b1;
    send_frame(9'h011, 10, -1, -1, seen, done_at, done_cnt, busy_low, busy_end, lat);
    checks++;
    if (o_rxdata !== 9'h011 || o_ferr !== 1'b0 || lat < 154 || lat > 156) begin
      errors++; $display("FAIL ovr_first: got data=0x%0h ferr=%b lat=%0d expected 0x11 0 154..156",
                         o_rxdata, o_ferr, lat);
    end
    send_frame(9'h022, 10, -1, -1, seen, done_at, done_cnt, busy_low, busy_end, rx_at);
    checks++;
    if (o_rxdata !== 9'h022 || o_valid !== 1'b1 || o_ovr !== 1'b1) begin
      errors++; $display("FAIL ovr_set: got data=0x%0h valid=%b ovr=%b expected 0x22 1 1",
                         o_rxdata, o_valid, o_ovr);
    end
    pulse_read();
    checks++;
    if (o_valid !== 1'b0 || o_ovr !== 1'b0 || o_rxdata !== 9'h022) begin
      errors++; $display("FAIL ovr_clear: got valid=%b ovr=%b data=0x%0h expected 0 0 0x22",
                         o_valid, o_ovr, o_rxdata);
    end
    send_frame(9'h011, 10, -1, -1, seen, done_at, done_cnt, busy_low, busy_end, rx_at);
    send_frame(9'h022, 10, -1, lat - 1, seen, done_at, done_cnt, busy_low, busy_end, rx_at);
    checks++;
    if (o_rxdata !== 9'h022 || o_valid !== 1'b1 || o_ovr !== 1'b0) begin
      errors++; $display("FAIL ovr_simul_read: got data=0x%0h valid=%b ovr=%b expected 0x22 1 0",
                         o_rxdata, o_valid, o_ovr);
    end
    pulse_read();
  endtask

  task automatic test_glitch_busy();
    logic [11:0] seen; int done_at, done_cnt, busy_low, rx_at, vcnt, bcnt; logic busy_end;
    sel = 1'b0; vcnt = 0; bcnt = 0;
    drv_a = 1'b1; loop_a = 1'b0;
    @(negedge tck); drv_a = 1'b0;
    repeat (4) @(negedge tck);
    drv_a = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge tck);
      if (valid_a) vcnt++;
    end
    $display("txn: rx glitch 4 cycles valid_cycles=%0d", vcnt);
    checks++;
    if (vcnt !== 0) begin errors++; $display("FAIL glitch: got valid_cycles=%0d expected 0", vcnt); end
    loop_a = 1'b1;
    send_frame(9'h0C3, 10, 40, -1, seen, done_at, done_cnt, busy_low, busy_end, rx_at);
    for (int i = 0; i < 20; i++) begin
      @(negedge tck);
      if (busy_a || !txd_a) bcnt++;
    end
    checks++;
    if (seen !== 12'h386 || done_cnt !== 1 || busy_end !== 1'b0 || bcnt !== 0) begin
      errors++; $display("FAIL busy_ignore: got bits=0x%0h done_cnt=%0d busy_end=%b extra=%0d expected 0x386 1 0 0",
                         seen, done_cnt, busy_end, bcnt);
    end
    checks++;
    if (rxdata_a !== 8'hC3) begin errors++; $display("FAIL busy_rx: got 0x%0h expected 0xc3", rxdata_a); end
    pulse_read();
  endtask

  task automatic test_reset_mid_tx();
    logic [11:0] seen; int done_at, done_cnt, busy_low, rx_at; logic busy_end;
    sel = 1'b0; loop_a = 1'b1;
    @(negedge tck); txdata_a = 8'h00; txen_a = 1'b1;
    @(negedge tck); txen_a = 1'b0;
    repeat (50) @(negedge tck);
    checks++;
    if (txd_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL mid_frame: got txd=%b busy=%b expected 0 1", txd_a, busy_a);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (txd_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++; $display("FAIL async_reset: got txd=%b busy=%b done=%b expected 1 0 0", txd_a, busy_a, done_a);
    end
    @(negedge tck); @(negedge tck);
    reset = 1'b1;
    $display("txn: reset pulse mid-frame");
    send_frame(9'h05A, 10, -1, -1, seen, done_at, done_cnt, busy_low, busy_end, rx_at);
    checks++;
    if (seen !== 12'h2B4 || done_at !== 159 || o_rxdata !== 9'h05A || o_valid !== 1'b1) begin
      errors++; $display("FAIL after_reset: got bits=0x%0h done_at=%0d data=0x%0h valid=%b expected 0x2b4 159 0x5a 1",
                         seen, done_at, o_rxdata, o_valid);
    end
  endtask

  initial begin
    sel = 1'b0;
    txen_a = 1'b0; txen_b = 1'b0; read_a = 1'b0; read_b = 1'b0;
    txdata_a = '0; txdata_b = '0;
    loop_a = 1'b1; loop_b = 1'b1; drv_a = 1'b1; drv_b = 1'b1;
    test_reset();
    test_loopback_8n1();
    test_parity_7e2();
    test_frame_err();
    test_overrun();
    test_glitch_busy();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
